power_mode_ctrl: RTL and testbench

//  Sequences the system clock sources between run and sleep modes.

---
 rtl/power_mode_ctrl.sv | 133 +++++++++++++
 tb/tb_power_mode_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/power_mode_ctrl.sv
// Run/sleep sequencer for the system clock sources, running on the always-on clock.
// Drains to sleep after an idle settle window and wakes on an external event or a timer.
module power_mode_ctrl #(
    parameter int WAKE_CNT_W    = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  aon_clk,
    input  logic                  reset,
    input  logic                  sleep_req,
    input  logic                  busy,
    input  logic                  wake_evt,
    input  logic [WAKE_CNT_W-1:0] wake_period,
    output logic                  clk_enable,
    output logic                  lsi_enable,
    output logic                  sleep_ack,
    output logic                  wake_irq,
    output logic [1:0]            wake_cause,
    output logic [1:0]            state
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_SLEEP  = 2'b10,
        ST_WAKEUP = 2'b11
    } state_t;

    state_t                  state_reg, state_next;
    logic [SETTLE_W-1:0]     settle_cnt_reg, settle_cnt_next;
    logic [WAKE_CNT_W-1:0]   wake_cnt_reg, wake_cnt_next;
    logic [1:0]              wake_cause_reg, wake_cause_next;
    logic                    sleep_req_q_reg;
    logic                    clk_enable_reg;
    logic                    lsi_enable_reg;
    logic                    sleep_ack_reg;
    logic                    wake_irq_reg;

    logic                    rise;
    logic                    timer_wake;
    logic [SETTLE_W-1:0]     settle_inc;

    assign rise       = sleep_req & ~sleep_req_q_reg;
    assign timer_wake = (wake_cnt_reg == WAKE_CNT_W'(1));
    // Saturating increment shared by the DRAIN idle window and the WAKEUP restart window.
    assign settle_inc = (settle_cnt_reg == SETTLE_MAX) ? settle_cnt_reg
                                                       : settle_cnt_reg + SETTLE_W'(1);

    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        wake_cnt_next   = wake_cnt_reg;
        wake_cause_next = wake_cause_reg;
        case (state_reg)
            ST_RUN: begin
                if (rise) begin
                    state_next      = ST_DRAIN;
                    settle_cnt_next = '0;
                end
            end
            ST_DRAIN: begin
                if (!sleep_req) begin
                    state_next      = ST_RUN;
                    settle_cnt_next = '0;
                end else if (busy) begin
                    settle_cnt_next = '0;
                end else begin
                    settle_cnt_next = settle_inc;
                    if (settle_inc == SETTLE_MAX) begin
                        state_next      = ST_SLEEP;
                        wake_cnt_next   = wake_period;
                        wake_cause_next = 2'b00;
                    end
                end
            end
            ST_SLEEP: begin
                if (wake_cnt_reg != '0) begin
                    wake_cnt_next = wake_cnt_reg - WAKE_CNT_W'(1);
                end
                if (wake_evt || timer_wake) begin
                    state_next      = ST_WAKEUP;
                    settle_cnt_next = '0;
                    wake_cnt_next   = '0;
                    wake_cause_next = {timer_wake, wake_evt};
                end
            end
            ST_WAKEUP: begin
                settle_cnt_next = settle_inc;
                if (settle_inc == SETTLE_MAX) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge aon_clk) begin
        if (!reset) begin
            state_reg       <= ST_RUN;
            settle_cnt_reg  <= '0;
            wake_cnt_reg    <= '0;
            wake_cause_reg  <= 2'b00;
            sleep_req_q_reg <= 1'b0;
            clk_enable_reg  <= 1'b1;
            lsi_enable_reg  <= 1'b0;
            sleep_ack_reg   <= 1'b0;
            wake_irq_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            settle_cnt_reg  <= settle_cnt_next;
            wake_cnt_reg    <= wake_cnt_next;
            wake_cause_reg  <= wake_cause_next;
            sleep_req_q_reg <= sleep_req;
            // Enables are decoded from the next state so they change on the transition edge.
            clk_enable_reg  <= (state_next != ST_SLEEP);
            lsi_enable_reg  <= (state_next == ST_SLEEP) || (state_next == ST_WAKEUP);
            sleep_ack_reg   <= (state_next == ST_SLEEP);
            wake_irq_reg    <= (state_reg == ST_WAKEUP) && (state_next == ST_RUN);
        end
    end

    assign clk_enable = clk_enable_reg;
    assign lsi_enable = lsi_enable_reg;
    assign sleep_ack  = sleep_ack_reg;
    assign wake_irq   = wake_irq_reg;
    assign wake_cause = wake_cause_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_power_mode_ctrl.sv
// Directed bench for power_mode_ctrl: sleep entry, busy extension, abort, timer/event wake, reset.
module tb_power_mode_ctrl;

    localparam logic [1:0] RUN    = 2'b00;
    localparam logic [1:0] DRAIN  = 2'b01;
    localparam logic [1:0] SLEEP  = 2'b10;
    localparam logic [1:0] WAKEUP = 2'b11;

    logic        aon_clk;
    logic        reset;
    logic        sleep_req;
    logic        busy;
    logic        wake_evt;
    logic [15:0] wake_period;
    logic        clk_enable;
    logic        lsi_enable;
    logic        sleep_ack;
    logic        wake_irq;
    logic [1:0]  wake_cause;
    logic [1:0]  state;

    int n_checks;
    int n_pass;

    power_mode_ctrl #(
        .WAKE_CNT_W    (16),
        .SETTLE_CYCLES (4)
    ) dut (
        .aon_clk     (aon_clk),
        .reset       (reset),
        .sleep_req   (sleep_req),
        .busy        (busy),
        .wake_evt    (wake_evt),
        .wake_period (wake_period),
        .clk_enable  (clk_enable),
        .lsi_enable  (lsi_enable),
        .sleep_ack   (sleep_ack),
        .wake_irq    (wake_irq),
        .wake_cause  (wake_cause),
        .state       (state)
    );

    initial aon_clk = 1'b0;
    always #5 aon_clk = ~aon_clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic ce,
                              input logic le, input logic sa, input logic irq,
                              input logic [1:0] cause);
        check({tag, ".state"},      16'(state),      16'(st));
        check({tag, ".clk_enable"}, 16'(clk_enable), 16'(ce));
        check({tag, ".lsi_enable"}, 16'(lsi_enable), 16'(le));
        check({tag, ".sleep_ack"},  16'(sleep_ack),  16'(sa));
        check({tag, ".wake_irq"},   16'(wake_irq),   16'(irq));
        check({tag, ".wake_cause"}, 16'(wake_cause), 16'(cause));
        $display("%0t %s state=%0d ce=%0b le=%0b ack=%0b irq=%0b cause=%0b", $time, tag,
                 state, clk_enable, lsi_enable, sleep_ack, wake_irq, wake_cause);
    endtask

    // Advance n rising edges; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge aon_clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b0;
        sleep_req   = 1'b0;
        busy        = 1'b0;
        wake_evt    = 1'b0;
        wake_period = 16'd0;
        tick(3);
        check_outs("init_reset", RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        reset = 1'b1;
        tick(2);
        check_outs("idle_run", RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

        // T2: plain sleep entry
        sleep_req = 1'b1;
        tick(1);
        check_outs("t2_drain", DRAIN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        tick(3);
        check_outs("t2_drain3", DRAIN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        tick(1);
        check_outs("t2_sleep", SLEEP, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(3);
        check_outs("t2_sleep_hold", SLEEP, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);

        // T1: reset mid-SLEEP
        reset     = 1'b0;
        sleep_req = 1'b0;
        tick(1);
        check_outs("t1_reset_e1", RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        tick(2);
        check_outs("t1_reset_e3", RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        reset = 1'b1;
        tick(1);
        check_outs("t1_release", RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

        // T3: busy on the 3rd DRAIN cycle restarts the settle window
        sleep_req = 1'b1;
        tick(1);
        check_outs("t3_drain", DRAIN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        tick(2);
        busy = 1'b1;
        tick(1);
        busy = 1'b0;
        tick(1);
        check_outs("t3_no_early_sleep", DRAIN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        tick(2);
        check_outs("t3_drain_late", DRAIN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        // wake_evt on the entry edge must be ignored
        wake_evt = 1'b1;
        tick(1);
        wake_evt = 1'b0;
        check_outs("t3_sleep", SLEEP, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);

        // T6: event wake with timer disabled
        tick(2);
        check_outs("t6_sleep_hold", SLEEP, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        wake_evt = 1'b1;
        tick(1);
        wake_evt = 1'b0;
        check_outs("t6_wakeup", WAKEUP, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
        tick(3);
        check_outs("t6_wakeup3", WAKEUP, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
        tick(1);
        check_outs("t6_run_irq", RUN, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
        tick(1);
        check_outs("t6_irq_gone", RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        tick(10);
        check_outs("t6_held_req", RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);

        // T4: abort during DRAIN
        sleep_req = 1'b0;
        tick(1);
        sleep_req = 1'b1;
        tick(2);
        check_outs("t4_drain", DRAIN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        sleep_req = 1'b0;
        tick(1);
        check_outs("t4_abort", RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        tick(5);
        check_outs("t4_stay_run", RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);

        // T5: timer wake, wake_period=10 latched at entry
        wake_period = 16'd10;
        sleep_req   = 1'b1;
        tick(5);
        check_outs("t5_sleep", SLEEP, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        wake_period = 16'd3;
        tick(9);
        check_outs("t5_sleep9", SLEEP, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(1);
        check_outs("t5_wakeup", WAKEUP, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
        tick(4);
        check_outs("t5_run_irq", RUN, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10);
        tick(1);
        check_outs("t5_irq_gone", RUN, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);

        // Simultaneous timer and event wake sets both cause bits
        wake_period = 16'd2;
        sleep_req   = 1'b0;
        tick(1);
        sleep_req = 1'b1;
        tick(5);
        check_outs("both_sleep", SLEEP, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        tick(1);
        check_outs("both_sleep1", SLEEP, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        wake_evt = 1'b1;
        tick(1);
        wake_evt = 1'b0;
        check_outs("both_wakeup", WAKEUP, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
